// File: rtl/fb_update_sequencer_pkg.sv
// Shared definitions for the block framebuffer update sequencer: field widths,
// colour constants, command layout and FSM encoding.
package fb_update_sequencer_pkg;

   localparam int unsigned X_W     = 7;
   localparam int unsigned Y_W     = 6;
   localparam int unsigned COLOR_W = 12;
   localparam int unsigned CMD_W   = 2 * X_W + 2 * Y_W + COLOR_W;

   localparam logic [COLOR_W-1:0] BLACK  = 12'h000;
   localparam logic [COLOR_W-1:0] WHITE  = 12'hFFF;
   localparam logic [COLOR_W-1:0] RED    = 12'hF00;
   localparam logic [COLOR_W-1:0] GREEN  = 12'h0F0;
   localparam logic [COLOR_W-1:0] BLUE   = 12'h00F;
   localparam logic [COLOR_W-1:0] YELLOW = 12'hFF0;
   localparam logic [COLOR_W-1:0] CYAN   = 12'h0FF;
   localparam logic [COLOR_W-1:0] PURPLE = 12'hA0F;
   localparam logic [COLOR_W-1:0] ORANGE = 12'hF80;

   typedef struct packed {
      logic [X_W-1:0]     x;
      logic [Y_W-1:0]     y;
      logic [X_W-1:0]     w;
      logic [Y_W-1:0]     h;
      logic [COLOR_W-1:0] color;
   } cmd_t;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_LOAD,
      ST_WRITE,
      ST_GAP
   } state_t;

   // 8-bit arithmetic keeps origin+length from wrapping for 7-bit fields.
   function automatic logic [7:0] clip_len(input logic [7:0] org,
                                           input logic [7:0] len,
                                           input logic [7:0] lim);
      return (org + len > lim) ? lim - org : len;
   endfunction

endpackage

// File: rtl/fb_update_sequencer_cmd_fifo.sv
// Show-ahead synchronous command queue with occupancy count and full/empty flags.
module fb_update_sequencer_cmd_fifo #(
   parameter int unsigned WIDTH = 38,
   parameter int unsigned DEPTH = 4
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         wr_en,
   input  logic [WIDTH-1:0]             wr_data,
   input  logic                         rd_en,
   output logic [WIDTH-1:0]             rd_data,
   output logic                         full,
   output logic                         empty,
   output logic [$clog2(DEPTH):0]       count
);

   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0]    mem [DEPTH];
   logic [AW-1:0]       wr_ptr;
   logic [AW-1:0]       rd_ptr;
   logic [$clog2(DEPTH):0] cnt;
   logic                do_wr;
   logic                do_rd;

   assign full    = (cnt == ($clog2(DEPTH) + 1)'(DEPTH));
   assign empty   = (cnt == '0);
   assign count   = cnt;
   assign do_wr   = wr_en && !full;
   assign do_rd   = rd_en && !empty;
   assign rd_data = mem[rd_ptr];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (do_wr) wr_ptr <= wr_ptr + 1'b1;
         if (do_rd) rd_ptr <= rd_ptr + 1'b1;
         case ({do_wr, do_rd})
            2'b10:   cnt <= cnt + 1'b1;
            2'b01:   cnt <= cnt - 1'b1;
            default: cnt <= cnt;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_wr) mem[wr_ptr] <= wr_data;
   end

endmodule

// File: rtl/fb_update_sequencer.sv
// Queues fill-rectangle commands and expands each into paced, raster-ordered
// block writes on the framebuffer update port.
module fb_update_sequencer
   import fb_update_sequencer_pkg::*;
#(
   parameter int unsigned GRID_W      = 20,
   parameter int unsigned GRID_H      = 15,
   parameter int unsigned FIFO_DEPTH  = 4,
   parameter int unsigned HOLD_CYCLES = 2,
   parameter int unsigned GAP_CYCLES  = 1
) (
   input  logic               iCLK,
   input  logic               iRST,
   input  logic               iCMD_VALID,
   output logic               oCMD_READY,
   input  logic [X_W-1:0]     iCMD_X,
   input  logic [Y_W-1:0]     iCMD_Y,
   input  logic [X_W-1:0]     iCMD_W,
   input  logic [Y_W-1:0]     iCMD_H,
   input  logic [COLOR_W-1:0] iCMD_COLOR,
   output logic               oUPDATE_EN,
   output logic [X_W-1:0]     oUPDATE_X,
   output logic [Y_W-1:0]     oUPDATE_Y,
   output logic [COLOR_W-1:0] oUPDATE_DATA,
   output logic               oBUSY
);

   localparam int unsigned CW    = $clog2(FIFO_DEPTH) + 1;
   localparam int unsigned CMAX  = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
   localparam int unsigned CNT_W = (CMAX > 1) ? $clog2(CMAX) : 1;

   state_t             state, state_nxt;
   cmd_t               cmd_in, head;
   logic               fifo_full, fifo_empty;
   logic [CW-1:0]      fifo_count, count_nxt;
   logic               push, pop, discard, hold_done, gap_done, last_blk;
   logic [7:0]         eff_w, eff_h;

   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [X_W-1:0]     x_q, x_d, x0_q, x0_d, xl_q, xl_d;
   logic [Y_W-1:0]     y_q, y_d, yl_q, yl_d;
   logic [COLOR_W-1:0] data_q, data_d;
   logic               en_q, en_d, ready_q, busy_q;

   assign cmd_in    = {iCMD_X, iCMD_Y, iCMD_W, iCMD_H, iCMD_COLOR};
   assign push      = iCMD_VALID && ready_q && !fifo_full;
   assign pop       = (state == ST_LOAD);
   assign count_nxt = fifo_count + CW'(push) - CW'(pop);

   fb_update_sequencer_cmd_fifo #(
      .WIDTH (CMD_W),
      .DEPTH (FIFO_DEPTH)
   ) u_cmd_fifo (
      .clk     (iCLK),
      .rst     (iRST),
      .wr_en   (push),
      .wr_data (cmd_in),
      .rd_en   (pop),
      .rd_data (head),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .count   (fifo_count)
   );

   assign discard   = ({1'b0, head.x} >= 8'(GRID_W)) || ({2'b0, head.y} >= 8'(GRID_H)) ||
                      (head.w == '0) || (head.h == '0);
   assign eff_w     = clip_len({1'b0, head.x}, {1'b0, head.w}, 8'(GRID_W));
   assign eff_h     = clip_len({2'b0, head.y}, {2'b0, head.h}, 8'(GRID_H));
   assign hold_done = (cnt_q == CNT_W'(HOLD_CYCLES - 1));
   assign gap_done  = (cnt_q == CNT_W'(GAP_CYCLES - 1));
   assign last_blk  = (x_q == xl_q) && (y_q == yl_q);

   always_ff @(posedge iCLK or posedge iRST) begin
      if (iRST) state <= ST_IDLE;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:  if (!fifo_empty) state_nxt = ST_LOAD;
         ST_LOAD: begin
            if (discard) state_nxt = (fifo_count > CW'(1)) ? ST_LOAD : ST_IDLE;
            else         state_nxt = ST_WRITE;
         end
         ST_WRITE: if (hold_done) state_nxt = ST_GAP;
         ST_GAP: begin
            if (gap_done) begin
               if (!last_blk)        state_nxt = ST_WRITE;
               else if (!fifo_empty) state_nxt = ST_LOAD;
               else                  state_nxt = ST_IDLE;
            end
         end
         default:  state_nxt = ST_IDLE;
      endcase
   end

   // Output registers are loaded from next values so every port is a flop.
   always_comb begin
      en_d   = 1'b0;
      x_d    = x_q;
      y_d    = y_q;
      data_d = data_q;
      x0_d   = x0_q;
      xl_d   = xl_q;
      yl_d   = yl_q;
      cnt_d  = '0;
      if ((state_nxt == state) && (state == ST_WRITE || state == ST_GAP))
         cnt_d = cnt_q + 1'b1;
      case (state)
         ST_LOAD: begin
            if (!discard) begin
               en_d   = 1'b1;
               x_d    = head.x;
               y_d    = head.y;
               data_d = head.color;
               x0_d   = head.x;
               xl_d   = X_W'({1'b0, head.x} + eff_w - 8'd1);
               yl_d   = Y_W'({2'b0, head.y} + eff_h - 8'd1);
            end
         end
         ST_WRITE: en_d = !hold_done;
         ST_GAP: begin
            if (gap_done && !last_blk) begin
               en_d = 1'b1;
               if (x_q == xl_q) begin
                  x_d = x0_q;
                  y_d = y_q + 1'b1;
               end else begin
                  x_d = x_q + 1'b1;
               end
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge iCLK or posedge iRST) begin
      if (iRST) begin
         cnt_q   <= '0;
         x_q     <= '0;
         y_q     <= '0;
         data_q  <= '0;
         x0_q    <= '0;
         xl_q    <= '0;
         yl_q    <= '0;
         en_q    <= 1'b0;
         ready_q <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         x_q     <= x_d;
         y_q     <= y_d;
         data_q  <= data_d;
         x0_q    <= x0_d;
         xl_q    <= xl_d;
         yl_q    <= yl_d;
         en_q    <= en_d;
         ready_q <= (count_nxt != CW'(FIFO_DEPTH));
         busy_q  <= (state_nxt != ST_IDLE) || (count_nxt != '0);
      end
   end

   assign oCMD_READY   = ready_q;
   assign oUPDATE_EN   = en_q;
   assign oUPDATE_X    = x_q;
   assign oUPDATE_Y    = y_q;
   assign oUPDATE_DATA = data_q;
   assign oBUSY        = busy_q;

endmodule

// File: tb/tb_fb_update_sequencer.sv
// Directed bench for fb_update_sequencer: strobe monitor plus hand-computed
// expectations for latency, clipping, raster order, back-pressure and reset.
module tb_fb_update_sequencer;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        cmd_valid = 1'b0;
   logic [6:0]  cmd_x = '0, cmd_w = '0;
   logic [5:0]  cmd_y = '0, cmd_h = '0;
   logic [11:0] cmd_color = '0;
   logic        cmd_ready, upd_en, busy;
   logic [6:0]  upd_x;
   logic [5:0]  upd_y;
   logic [11:0] upd_data;

   always #5 clk = ~clk;

   fb_update_sequencer #(
      .GRID_W      (20),
      .GRID_H      (15),
      .FIFO_DEPTH  (4),
      .HOLD_CYCLES (2),
      .GAP_CYCLES  (1)
   ) dut (
      .iCLK         (clk),
      .iRST         (rst),
      .iCMD_VALID   (cmd_valid),
      .oCMD_READY   (cmd_ready),
      .iCMD_X       (cmd_x),
      .iCMD_Y       (cmd_y),
      .iCMD_W       (cmd_w),
      .iCMD_H       (cmd_h),
      .iCMD_COLOR   (cmd_color),
      .oUPDATE_EN   (upd_en),
      .oUPDATE_X    (upd_x),
      .oUPDATE_Y    (upd_y),
      .oUPDATE_DATA (upd_data),
      .oBUSY        (busy)
   );

   typedef struct {
      int unsigned x;
      int unsigned y;
      int unsigned d;
      int unsigned c;
   } strobe_t;

   strobe_t     sq[$];
   int unsigned tests = 0, fails = 0, cyc = 0;
   int unsigned hold_bad = 0, stab_bad = 0, hold_len = 0;
   logic        en_prev = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   // Records each strobe and checks its length and field stability.
   always @(negedge clk) begin
      if (rst) begin
         en_prev  = 1'b0;
         hold_len = 0;
      end else begin
         if (upd_en && !en_prev) begin
            sq.push_back('{int'(upd_x), int'(upd_y), int'(upd_data), cyc});
            hold_len = 1;
         end else if (upd_en) begin
            hold_len++;
            if (sq[$].x != int'(upd_x) || sq[$].y != int'(upd_y) || sq[$].d != int'(upd_data))
               stab_bad++;
         end else if (en_prev && hold_len != 2) begin
            hold_bad++;
         end
         en_prev = upd_en;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic set_cmd(input int unsigned x, y, w, h, c);
      cmd_x     = 7'(x);
      cmd_y     = 6'(y);
      cmd_w     = 7'(w);
      cmd_h     = 6'(h);
      cmd_color = 12'(c);
   endtask

   task automatic send_cmd(input int unsigned x, y, w, h, c);
      int unsigned n = 0;
      @(negedge clk);
      set_cmd(x, y, w, h, c);
      cmd_valid = 1'b1;
      while (!cmd_ready && n < 5000) begin
         @(negedge clk);
         n++;
      end
      chk("send_timeout", 32'(n < 5000), 1);
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
   endtask

   task automatic wait_idle(input int unsigned limit);
      int unsigned n = 0;
      repeat (2) @(negedge clk);
      while (busy && n < limit) begin
         @(negedge clk);
         n++;
      end
      chk("idle_timeout", 32'(n < limit), 1);
   endtask

   task automatic wait_strobes(input int unsigned cnt, input int unsigned limit);
      int unsigned n = 0;
      while (sq.size() < cnt && n < limit) begin
         @(negedge clk);
         n++;
      end
      chk("strobe_timeout", 32'(sq.size() >= cnt), 1);
   endtask

   initial begin
      int unsigned err;
      int unsigned n;

      // Reset state
      repeat (3) @(negedge clk);
      chk("rst_ready", cmd_ready, 0);
      chk("rst_en", upd_en, 0);
      chk("rst_busy", busy, 0);
      rst = 1'b0;
      @(negedge clk);
      chk("post_rst_ready", cmd_ready, 1);
      chk("post_rst_x", upd_x, 0);

      // 1: single block, latency and strobe length
      sq.delete();
      send_cmd(5, 3, 1, 1, 12'hF00);
      @(negedge clk);
      chk("t1_busy_t0", busy, 1);
      chk("t1_en_t0", upd_en, 0);
      @(negedge clk);
      chk("t1_en_load", upd_en, 0);
      @(negedge clk);
      chk("t1_en_first", upd_en, 1);
      chk("t1_x", upd_x, 5);
      chk("t1_y", upd_y, 3);
      chk("t1_data", upd_data, 12'hF00);
      @(negedge clk);
      chk("t1_en_hold", upd_en, 1);
      @(negedge clk);
      chk("t1_en_gap", upd_en, 0);
      chk("t1_busy_gap", busy, 1);
      @(negedge clk);
      chk("t1_busy_done", busy, 0);
      chk("t1_count", sq.size(), 1);

      // 2: corner clip to 2x1
      sq.delete();
      send_cmd(18, 14, 3, 2, 12'h0F0);
      wait_idle(200);
      chk("t2_count", sq.size(), 2);
      if (sq.size() == 2) begin
         chk("t2_s0", {sq[0].x[7:0], sq[0].y[7:0], sq[0].d[15:0]}, {8'd18, 8'd14, 16'h0F0});
         chk("t2_s1", {sq[1].x[7:0], sq[1].y[7:0], sq[1].d[15:0]}, {8'd19, 8'd14, 16'h0F0});
      end

      // 2b: oversized W/H from the last column, 7-bit sums would wrap
      sq.delete();
      send_cmd(19, 0, 127, 63, 12'hFF0);
      wait_idle(400);
      chk("t2b_count", sq.size(), 15);
      if (sq.size() == 15)
         chk("t2b_last", {sq[14].x[7:0], sq[14].y[7:0]}, {8'd19, 8'd14});

      // 3: full-screen clear, raster order and cycle span
      sq.delete();
      send_cmd(0, 0, 20, 15, 12'h000);
      wait_idle(2000);
      chk("t3_count", sq.size(), 300);
      if (sq.size() == 300) begin
         err = 0;
         for (int unsigned i = 0; i < 300; i++)
            if (sq[i].x != i % 20 || sq[i].y != i / 20 || sq[i].d != 0) err++;
         chk("t3_order", err, 0);
         chk("t3_span", sq[299].c - sq[0].c, 299 * 3);
      end

      // 4: back-pressure while a long fill runs
      sq.delete();
      send_cmd(0, 0, 20, 15, 12'h00F);
      wait_strobes(1, 100);
      for (int unsigned i = 0; i < 4; i++) begin
         @(negedge clk);
         set_cmd(i, i, 1, 1, 12'h100 + i);
         cmd_valid = 1'b1;
         @(posedge clk);
         #1;
         cmd_valid = 1'b0;
      end
      @(negedge clk);
      chk("t4_ready_full", cmd_ready, 0);
      chk("t4_busy", busy, 1);
      send_cmd(4, 4, 1, 1, 12'h104);
      send_cmd(5, 5, 1, 1, 12'h105);
      wait_idle(3000);
      chk("t4_count", sq.size(), 306);
      if (sq.size() == 306) begin
         err = 0;
         for (int unsigned i = 0; i < 6; i++)
            if (sq[300+i].x != i || sq[300+i].y != i || sq[300+i].d != 12'h100 + i) err++;
         chk("t4_order", err, 0);
      end

      // 5: discarded commands issue nothing
      sq.delete();
      send_cmd(3, 3, 0, 1, 12'h123);
      send_cmd(20, 0, 1, 1, 12'h456);
      send_cmd(0, 15, 1, 1, 12'h789);
      send_cmd(2, 2, 1, 1, 12'hFFF);
      wait_idle(200);
      chk("t5_count", sq.size(), 1);
      if (sq.size() == 1)
         chk("t5_s0", {sq[0].x[7:0], sq[0].y[7:0], sq[0].d[15:0]}, {8'd2, 8'd2, 16'hFFF});

      chk("hold_len", hold_bad, 0);
      chk("strobe_stable", stab_bad, 0);

      // 6: reset during the 50th strobe of a clear, with a command queued
      sq.delete();
      send_cmd(0, 0, 20, 15, 12'hABC);
      send_cmd(1, 1, 1, 1, 12'h111);
      wait_strobes(50, 400);
      rst = 1'b1;
      #1;
      chk("t6_en", upd_en, 0);
      chk("t6_xyd", {upd_x, upd_y, upd_data}, 0);
      chk("t6_ready", cmd_ready, 0);
      chk("t6_busy", busy, 0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      n = sq.size();
      chk("t6_at_rst", n, 50);
      @(negedge clk);
      chk("t6_ready_rel", cmd_ready, 1);
      chk("t6_busy_rel", busy, 0);
      repeat (100) @(negedge clk);
      chk("t6_no_strobes", sq.size(), n);
      chk("t6_en_rel", upd_en, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
